// File: rtl/link_round_robin_arbiter_pkg.sv
// link_round_robin_arbiter_pkg: shared interconnect types for the link arbiter
//   PACKET_WIDTH         width of one link packet
//   DEFAULT_NUM_SOURCES  default number of upstream senders sharing a link
//   packet_t             one link packet
//   source_index_t       index of one upstream sender (default source count)
package link_round_robin_arbiter_pkg;
    localparam int PACKET_WIDTH        = 8;
    localparam int DEFAULT_NUM_SOURCES = 4;
    typedef logic [PACKET_WIDTH-1:0] packet_t;
    typedef logic [$clog2(DEFAULT_NUM_SOURCES)-1:0] source_index_t;
endpackage

// File: rtl/link_round_robin_arbiter_if.sv
// link_round_robin_arbiter_if: handshake bundle between upstream senders, arbiter and downstream buffer
//   enable       freeze control (low holds all arbiter state)
//   src_req      per-source packet valid
//   src_packet   per-source packet
//   src_ack      per-source accept, one-hot or zero
//   out_req      output slot valid
//   out_packet   output slot contents
//   out_ack      downstream accept
//   grant_index  source of the packet in the output slot
//   quiescent    slot empty and nothing requesting
//   modport slave is the arbiter side, master the environment side
interface link_round_robin_arbiter_if
    import link_round_robin_arbiter_pkg::*;
#(
    parameter int NUM_SOURCES = DEFAULT_NUM_SOURCES
);
    localparam int IW = $clog2(NUM_SOURCES);
    logic                          enable;
    logic [NUM_SOURCES-1:0]        src_req;
    packet_t [NUM_SOURCES-1:0]     src_packet;
    logic [NUM_SOURCES-1:0]        src_ack;
    logic                          out_req;
    packet_t                       out_packet;
    logic                          out_ack;
    logic [IW-1:0]                 grant_index;
    logic                          quiescent;
    modport slave (
        input  enable, src_req, src_packet, out_ack,
        output src_ack, out_req, out_packet, grant_index, quiescent
    );
    modport master (
        output enable, src_req, src_packet, out_ack,
        input  src_ack, out_req, out_packet, grant_index, quiescent
    );
endinterface

// File: rtl/link_round_robin_arbiter_picker.sv
// round_robin_picker: combinational round-robin selection starting at a pointer
//   i_req    request vector
//   i_ptr    highest-priority source this cycle
//   o_grant  one-hot grant (zero when nothing requests)
//   o_index  index of the granted source
//   o_any    some source is granted
module round_robin_picker
#(
    parameter int NUM_SOURCES = 4
) (
    input  logic [NUM_SOURCES-1:0]         i_req,
    input  logic [$clog2(NUM_SOURCES)-1:0] i_ptr,
    output logic [NUM_SOURCES-1:0]         o_grant,
    output logic [$clog2(NUM_SOURCES)-1:0] o_index,
    output logic                           o_any
);
    localparam int IW = $clog2(NUM_SOURCES);
    logic [IW-1:0] w_idx;
    // Scan offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        w_idx   = '0;
        o_index = '0;
        o_any   = 1'b0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            w_idx = IW'((int'(i_ptr) + i) % NUM_SOURCES);
            if (i_req[w_idx]) begin
                o_index = w_idx;
                o_any   = 1'b1;
            end
        end
        o_grant = o_any ? (NUM_SOURCES'(1) << o_index) : '0;
    end
endmodule

// File: rtl/link_round_robin_arbiter.sv
// link_round_robin_arbiter: round-robin sharing of one registered output link among NUM_SOURCES senders
//   clock  positive-edge clock
//   reset  synchronous active-high reset
//   bus    arbiter side of link_round_robin_arbiter_if (source handshakes, output slot, status)
module link_round_robin_arbiter
    import link_round_robin_arbiter_pkg::*;
#(
    parameter int NUM_SOURCES = DEFAULT_NUM_SOURCES
) (
    input logic                        clock,
    input logic                        reset,
    link_round_robin_arbiter_if.slave  bus
);
    localparam int IW = $clog2(NUM_SOURCES);
    logic                   r_out_req;
    packet_t                r_out_packet;
    logic [IW-1:0]          r_grant_index;
    logic [IW-1:0]          r_ptr;
    logic [NUM_SOURCES-1:0] w_grant;
    logic [IW-1:0]          w_index;
    logic                   w_any;
    logic                   w_take;

    round_robin_picker #(.NUM_SOURCES(NUM_SOURCES)) u_picker (
        .i_req   (bus.src_req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_index (w_index),
        .o_any   (w_any)
    );

    // A source may be accepted only when the slot is empty or draining this cycle.
    assign w_take          = !reset && bus.enable && (!r_out_req || bus.out_ack);
    assign bus.src_ack     = w_take ? w_grant : '0;
    assign bus.out_req     = r_out_req;
    assign bus.out_packet  = r_out_packet;
    assign bus.grant_index = r_grant_index;
    assign bus.quiescent   = !r_out_req && (bus.src_req == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_req     <= 1'b0;
            r_out_packet  <= '0;
            r_grant_index <= '0;
            r_ptr         <= '0;
        end else if (bus.enable) begin
            if (w_take && w_any) begin
                r_out_req     <= 1'b1;
                r_out_packet  <= bus.src_packet[w_index];
                r_grant_index <= w_index;
                r_ptr         <= (w_index == IW'(NUM_SOURCES - 1)) ? '0 : w_index + 1'b1;
            end else if (bus.out_ack && r_out_req) begin
                r_out_req <= 1'b0;
            end
        end
    end
endmodule
